si_tag_converter_filtered: RTL and testbench
============================================

Name: si_tag_converter_filtered

Overview:
- Multi-lane successor to the basic tag converter.
- Converts up to NUMBER_OF_WORDS raw 32-bit Time Tagger words per cycle into absolute 1/3 ps tag times and signed channel numbers.
- Adds: parametrised counter tick, runtime per-channel enable mask, emitted/filtered tag statistics, and defined zero outputs on invalid lanes.
- Sits between the FPGA-link stream unpacker and the user measurement logic, e.g. histogrammers.

Parameters:
- CHANNEL_COUNT, 20: internal channel count. Raw channel numbers 0..2*CHANNEL_COUNT-1 are valid.
- DATA_WIDTH_IN, 128: input data width in bits. Must be a multiple of 32.
- KEEP_WIDTH_IN, DATA_WIDTH_IN/8: width of tkeep.
- NUMBER_OF_WORDS, DATA_WIDTH_IN/32: number of lanes.
- COUNTER_TICK, 4000: tag time per coarse counter tick, in 1/3 ps. Must be less than 2^20.

Ports:
- clk, input, 1: sole clock.
- rst_n, input, 1: reset, synchronous, active-low.
- s_axis_tvalid, input, 1: input beat valid.
- s_axis_tready, output, 1: input ready.
- s_axis_tdata, input, DATA_WIDTH_IN: raw words. Lane i occupies bits [32i+:32].
- s_axis_tkeep, input, KEEP_WIDTH_IN: byte keep. Lane i is usable only when nibble [4i+:4] is 4'hF.
- s_axis_tlast, input, 1: ignored.
- s_axis_tuser, input, 32: rollover (wrap) count for the beat.
- channel_enable, input, 2*CHANNEL_COUNT: bit n enables raw channel n. Quasi-static.
- m_axis_tvalid, output, 1: at least one output lane is valid.
- m_axis_tready, input, 1: downstream ready.
- m_axis_tagtime, output, 64 x NUMBER_OF_WORDS: tag time in 1/3 ps.
- m_axis_channel, output, signed 6 x NUMBER_OF_WORDS: +1..+CHANNEL_COUNT for rising edges, -1..-CHANNEL_COUNT for falling edges.
- m_axis_tkeep, output, NUMBER_OF_WORDS: per-lane valid.
- tag_count, output, 32: total tags emitted.
- filtered_count, output, 32: total tags dropped by channel_enable.
- mono_error, output, 1: sticky monotonicity error.

Behaviour:
- Raw word fields: event_type=[31:30], channel_number=[29:24], subtime=[23:12], counter=[11:0].
- Global enable en = m_axis_tready || !m_axis_tvalid. s_axis_tready = en. All stages advance only when en=1. No bubble collapsing.
- Pipeline stages, fixed latency of 4 en-cycles from accepted beat to output register:
  - S0: register each lane word. Lane word is forced to 0 unless s_axis_tvalid and its tkeep nibble is F. Register tuser.
  - S1: prod = {tuser, counter} * COUNTER_TICK, as a 44-bit x 20-bit product truncated to 64 bits.
  - S2: t = prod + subtime, zero-extended.
  - S3: decode lane and register the outputs.
- Lane decode:
  - decoded = (event_type==2'b01) && (channel_number < 2*CHANNEL_COUNT).
  - keep = decoded && channel_enable[channel_number].
  - channel = channel_number+1 if channel_number < CHANNEL_COUNT, else CHANNEL_COUNT-1-channel_number.
- Lanes with keep=0 output tagtime=0 and channel=0.
- m_axis_tvalid = |m_axis_tkeep. All-empty beats produce no output.
- channel_enable is sampled at S3. A change affects only beats reaching S3 on or after the next cycle.
- Counters are updated on each S3 load (en=1):
  - tag_count += popcount(keep).
  - filtered_count += popcount(decoded & ~keep).
  - Both are 32-bit and wrap modulo 2^32. There is no saturation.
- Held output: when m_axis_tvalid=1 and m_axis_tready=0, all outputs and pipeline contents hold. s_axis_tready=0.
- Reset (rst_n=0 at a clk edge):
  - All pipeline registers cleared. In-flight beats are discarded.
  - m_axis_tvalid=0, m_axis_tkeep=0, tagtime=0, channel=0, tag_count=0, filtered_count=0, mono_error=0.
  - s_axis_tready=1 during and after reset.

Optional Feature:
- Macro: SI_TAG_CONVERTER_MONOTONIC_CHECK_EN.
- Defined: a 64-bit register last_time holds the most recently emitted tagtime.
  - Emitted lanes are compared in ascending lane order within a beat, then across beats.
  - Any emitted tagtime < its predecessor sets mono_error=1 one cycle after the S3 load.
  - mono_error clears only on reset. last_time resets to 0.
- Undefined: no comparator logic is built. mono_error is tied to 0.

Test Plan:
- Basic rising-edge decode: tuser=1, lane0=0x43123005, tkeep=all F, all channels enabled -> after 4 cycles: tkeep[0]=1, tagtime[0]=16404291, channel[0]=+4, tag_count=1.
- Falling edge and invalid lanes: lane1 channel_number=22 (CC=20) -> channel=-3. Lane2 event_type=2'b00 and lane3 tkeep nibble=0x7 -> both keep=0 with tagtime=0, channel=0. Neither increments filtered_count.
- Channel filter: channel_enable[3]=0, 4 beats of 4 valid ch3 words -> m_axis_tvalid never asserted, filtered_count=16, tag_count=0.
- Back-pressure: m_axis_tready low for 10 cycles while 8 beats are offered -> s_axis_tready=0 while the output is held. No beat is lost or duplicated. Output order matches input order.
- Reset mid-stream: rst_n=0 for 1 cycle with 3 beats in flight -> no output from those beats, counters=0, next beat emerges after 4 cycles.
- Monotonicity (macro defined): beat A tagtime 1000, then beat B tagtime 900 -> mono_error=1 and sticky. Macro undefined -> mono_error stays 0.

Source files
------------

// File: rtl/si_tag_converter_filtered.sv
// Multi-lane Time Tagger word to absolute tag time / signed channel converter.
// Optional monotonicity checker built when SI_TAG_CONVERTER_MONOTONIC_CHECK_EN is defined.
module si_tag_converter_filtered #(
    parameter int CHANNEL_COUNT   = 20,
    parameter int DATA_WIDTH_IN   = 128,
    parameter int KEEP_WIDTH_IN   = DATA_WIDTH_IN/8,
    parameter int NUMBER_OF_WORDS = DATA_WIDTH_IN/32,
    parameter int COUNTER_TICK    = 4000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [DATA_WIDTH_IN-1:0]          s_axis_tdata,
    input  logic [KEEP_WIDTH_IN-1:0]          s_axis_tkeep,
    input  logic                              s_axis_tlast,
    input  logic [31:0]                       s_axis_tuser,
    input  logic [2*CHANNEL_COUNT-1:0]        channel_enable,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [64*NUMBER_OF_WORDS-1:0]     m_axis_tagtime,
    output logic signed [6*NUMBER_OF_WORDS-1:0] m_axis_channel,
    output logic [NUMBER_OF_WORDS-1:0]        m_axis_tkeep,
    output logic [31:0]                       tag_count,
    output logic [31:0]                       filtered_count,
    output logic                              mono_error
);

    localparam int NW = NUMBER_OF_WORDS;
    localparam logic [19:0] TICK = 20'(COUNTER_TICK);

    logic en;
    logic unused_tlast;

    logic [31:0] s0_word [NW];
    logic [31:0] s0_user;
    logic [63:0] s1_prod [NW];
    logic [19:0] s1_hi   [NW];
    logic [63:0] s2_time [NW];
    logic [7:0]  s2_id   [NW];

    logic [63:0]    en_ext;
    logic [NW-1:0]  dec;
    logic [NW-1:0]  keep;
    logic [5:0]     chan [NW];
    logic [31:0]    kcnt;
    logic [31:0]    fcnt;

    assign en = m_axis_tready || !m_axis_tvalid;
    // Never back-pressure the source while reset is flushing the pipe.
    assign s_axis_tready = en || !rst_n;
    assign unused_tlast = s_axis_tlast;
    assign en_ext = 64'(channel_enable);

    always_comb begin
        kcnt = '0;
        fcnt = '0;
        for (int i = 0; i < NW; i++) begin
            dec[i]  = (s2_id[i][7:6] == 2'b01) &&
                      (int'(s2_id[i][5:0]) < 2*CHANNEL_COUNT);
            keep[i] = dec[i] && en_ext[s2_id[i][5:0]];
            if (int'(s2_id[i][5:0]) < CHANNEL_COUNT)
                chan[i] = s2_id[i][5:0] + 6'd1;
            else
                chan[i] = 6'(CHANNEL_COUNT - 1 - int'(s2_id[i][5:0]));
            kcnt = kcnt + 32'(keep[i]);
            fcnt = fcnt + 32'(dec[i] && !keep[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_user        <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tkeep   <= '0;
            m_axis_tagtime <= '0;
            m_axis_channel <= '0;
            tag_count      <= '0;
            filtered_count <= '0;
            for (int i = 0; i < NW; i++) begin
                s0_word[i] <= '0;
                s1_prod[i] <= '0;
                s1_hi[i]   <= '0;
                s2_time[i] <= '0;
                s2_id[i]   <= '0;
            end
        end else if (en) begin
            s0_user <= s_axis_tuser;
            for (int i = 0; i < NW; i++) begin
                // Unusable lanes become event_type 0 and never decode.
                if (s_axis_tvalid && (s_axis_tkeep[4*i+:4] == 4'hF))
                    s0_word[i] <= s_axis_tdata[32*i+:32];
                else
                    s0_word[i] <= '0;
                s1_prod[i] <= 64'({s0_user, s0_word[i][11:0]}) * 64'(TICK);
                s1_hi[i]   <= s0_word[i][31:12];
                s2_time[i] <= s1_prod[i] + 64'(s1_hi[i][11:0]);
                s2_id[i]   <= s1_hi[i][19:12];
                m_axis_tagtime[64*i+:64] <= keep[i] ? s2_time[i] : 64'd0;
                m_axis_channel[6*i+:6]   <= keep[i] ? chan[i] : 6'd0;
            end
            m_axis_tkeep   <= keep;
            m_axis_tvalid  <= |keep;
            tag_count      <= tag_count + kcnt;
            filtered_count <= filtered_count + fcnt;
        end
    end

`ifdef SI_TAG_CONVERTER_MONOTONIC_CHECK_EN
    logic [63:0] last_time;
    logic [63:0] pred;
    logic        hit;
    logic        mono_hit;

    // Walk emitted lanes in ascending order, chaining from the last beat.
    always_comb begin
        pred = last_time;
        hit  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (keep[i]) begin
                if (s2_time[i] < pred)
                    hit = 1'b1;
                pred = s2_time[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_time  <= '0;
            mono_hit   <= 1'b0;
            mono_error <= 1'b0;
        end else begin
            mono_hit   <= en && hit;
            mono_error <= mono_error || mono_hit;
            if (en)
                last_time <= pred;
        end
    end
`else
    assign mono_error = 1'b0;
`endif

endmodule

// File: tb/tb_si_tag_converter_filtered.sv
// Directed self-checking bench for si_tag_converter_filtered.
// Define SI_TAG_CONVERTER_MONOTONIC_CHECK_EN to expect the checker enabled.
module tb_si_tag_converter_filtered;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [127:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic [31:0]  s_axis_tuser;
    logic [39:0]  channel_enable;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [255:0] m_axis_tagtime;
    logic signed [23:0] m_axis_channel;
    logic [3:0]   m_axis_tkeep;
    logic [31:0]  tag_count;
    logic [31:0]  filtered_count;
    logic         mono_error;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    si_tag_converter_filtered dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .channel_enable(channel_enable),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tagtime(m_axis_tagtime), .m_axis_channel(m_axis_channel),
        .m_axis_tkeep(m_axis_tkeep), .tag_count(tag_count),
        .filtered_count(filtered_count), .mono_error(mono_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
    endtask

    task automatic beat1(input logic [31:0] w0, input logic [31:0] user);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {96'd0, w0};
        s_axis_tkeep  = 16'h000F;
        s_axis_tuser  = user;
    endtask

    int nb;
    int got;
    int hold_seen;
    int hold_bad;
    logic seen;
    logic [63:0] held;

    initial begin
        rst_n = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        channel_enable = '1;
        idle();
        cyc(1);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
        cyc(1);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst_tagtime0", m_axis_tagtime[63:0], 64'd0);
        chk("rst_tag_count", 64'(tag_count), 64'd0);
        chk("rst_filtered", 64'(filtered_count), 64'd0);
        chk("rst_mono", 64'(mono_error), 64'd0);
        rst_n = 1'b1;

        // Rising ch3, falling raw 22, event_type 0, partial keep.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {32'h43123005, 32'h03123005,
                         32'h56000010, 32'h43123005};
        s_axis_tkeep  = 16'h7FFF;
        s_axis_tuser  = 32'd1;
        cyc(1);
        idle();
        cyc(2);
        chk("lat_tvalid_early", 64'(m_axis_tvalid), 64'd0);
        cyc(1);
        chk("dec_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("dec_tkeep", 64'(m_axis_tkeep), 64'h3);
        chk("dec_time0", m_axis_tagtime[63:0], 64'd16404291);
        chk("dec_chan0", 64'(m_axis_channel[5:0]), 64'h04);
        chk("dec_time1", m_axis_tagtime[127:64], 64'd16448000);
        chk("dec_chan1", 64'(m_axis_channel[11:6]), 64'h3D);
        chk("dec_time2", m_axis_tagtime[191:128], 64'd0);
        chk("dec_chan2", 64'(m_axis_channel[17:12]), 64'd0);
        chk("dec_time3", m_axis_tagtime[255:192], 64'd0);
        chk("dec_chan3", 64'(m_axis_channel[23:18]), 64'd0);
        chk("dec_tag_count", 64'(tag_count), 64'd2);
        chk("dec_filtered", 64'(filtered_count), 64'd0);

        // Channel filter: raw channel 3 masked.
        channel_enable[3] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {4{32'h43000001}};
                s_axis_tkeep  = 16'hFFFF;
            end else begin
                idle();
            end
            cyc(1);
            seen = seen | m_axis_tvalid;
        end
        chk("filt_tvalid_seen", 64'(seen), 64'd0);
        chk("filt_filtered", 64'(filtered_count), 64'd16);
        chk("filt_tag_count", 64'(tag_count), 64'd2);
        channel_enable = '1;

        // Back-pressure with 8 beats, ready low for 10 cycles.
        nb = 0; got = 0; hold_seen = 0; hold_bad = 0; held = '0;
        for (int c = 0; c < 40; c++) begin
            m_axis_tready = !(c >= 2 && c < 12);
            if (nb < 8) beat1(32'h43000000 | 32'(nb), 32'd0);
            else idle();
            #1;
            if (m_axis_tvalid && !m_axis_tready) begin
                if (hold_seen > 0 && m_axis_tagtime[63:0] !== held)
                    hold_bad++;
                held = m_axis_tagtime[63:0];
                hold_seen++;
                if (s_axis_tready) hold_bad++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk("bp_time", m_axis_tagtime[63:0], 64'(got * 4000));
                chk("bp_tkeep", 64'(m_axis_tkeep), 64'h1);
                got++;
            end
            if (s_axis_tvalid && s_axis_tready) nb++;
            cyc(1);
        end
        m_axis_tready = 1'b1;
        chk("bp_accepted", 64'(nb), 64'd8);
        chk("bp_emitted", 64'(got), 64'd8);
        chk("bp_hold_seen", 64'(hold_seen > 0), 64'd1);
        chk("bp_hold_bad", 64'(hold_bad), 64'd0);
        chk("bp_tag_count", 64'(tag_count), 64'd10);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            beat1(32'h43000007, 32'd0);
            cyc(1);
        end
        idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_tready", 64'(s_axis_tready), 64'd1);
        cyc(1);
        rst_n = 1'b1;
        chk("mid_tag_count", 64'(tag_count), 64'd0);
        chk("mid_filtered", 64'(filtered_count), 64'd0);
        seen = m_axis_tvalid;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            seen = seen | m_axis_tvalid;
        end
        chk("mid_no_output", 64'(seen), 64'd0);
        beat1(32'h43123005, 32'd1);
        cyc(1);
        idle();
        cyc(3);
        chk("post_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("post_time0", m_axis_tagtime[63:0], 64'd16404291);
        chk("post_tag_count", 64'(tag_count), 64'd1);

        // Monotonicity: 1000 then 900.
        beat1(32'h433E8000, 32'd0);
        cyc(1);
        beat1(32'h43384000, 32'd0);
        cyc(1);
        idle();
        cyc(2);
        chk("mono_a_time", m_axis_tagtime[63:0], 64'd1000);
        chk("mono_a_flag", 64'(mono_error), 64'd0);
        cyc(1);
        chk("mono_b_time", m_axis_tagtime[63:0], 64'd900);
`ifdef SI_TAG_CONVERTER_MONOTONIC_CHECK_EN
        chk("mono_b_flag_now", 64'(mono_error), 64'd0);
        cyc(1);
        chk("mono_set", 64'(mono_error), 64'd1);
        cyc(5);
        chk("mono_sticky", 64'(mono_error), 64'd1);
`else
        cyc(6);
        chk("mono_off", 64'(mono_error), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
